// File: rtl/park_gate_scheduler_pkg.sv
// Shared types and defaults for the car park gate scheduler.
package park_gate_scheduler_pkg;

    // Sequencer states, 3-bit encoding.
    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ENTRY_GRANT = 3'd1,
        S_BAR_IN      = 3'd2,
        S_EXIT_CHECK  = 3'd3,
        S_WAIT_PAY    = 3'd4,
        S_BAR_OUT     = 3'd5
    } state_t;

    // Default timing and billing constants.
    localparam int DEF_BAR_CYCLES = 5000;
    localparam int DEF_HOUR_SECS  = 3600;
    localparam int DEF_FEE_MAX    = 5;

    // Encoding of the last_served arbitration bit.
    localparam logic LS_ENTRY = 1'b0;
    localparam logic LS_EXIT  = 1'b1;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/park_gate_scheduler_timebase.sv
// Prescaler and seconds counter: sec_cnt advances once every TICK_DIV clocks.
module park_timebase
    import park_gate_scheduler_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int T_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    output logic [T_W-1:0] sec_cnt,
    output logic           tick
);

    localparam int PRE_W = cnt_w(TICK_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [T_W-1:0]   sec_q, sec_d;
    logic             tick_q, tick_d;
    logic             wrap_s;

    assign wrap_s  = (pre_q == PRE_W'(TICK_DIV - 1));
    assign sec_cnt = sec_q;
    assign tick    = tick_q;

    // Next-state for prescaler and seconds; seconds wrap modulo 2^T_W.
    always_comb begin
        pre_d  = pre_q;
        sec_d  = sec_q;
        tick_d = 1'b0;
        if (wrap_s) begin
            pre_d  = {PRE_W{1'b0}};
            sec_d  = sec_q + T_W'(1);
            tick_d = 1'b1;
        end else begin
            pre_d  = pre_q + PRE_W'(1);
        end
    end

    // Timebase registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= {PRE_W{1'b0}};
            sec_q  <= {T_W{1'b0}};
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            sec_q  <= sec_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/park_gate_scheduler.sv
// Car park sequencer: slot pool, shared bar timer, fee calculation.
module park_gate_scheduler
    import park_gate_scheduler_pkg::*;
#(
    parameter int N_SLOTS    = 5,
    parameter int SLOT_W     = 3,
    parameter int TICK_DIV   = 1000,
    parameter int T_W        = 16,
    parameter int HOUR_SECS  = DEF_HOUR_SECS,
    parameter int FEE_MAX    = DEF_FEE_MAX,
    parameter int FEE_W      = 4,
    parameter int BAR_CYCLES = DEF_BAR_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [SLOT_W-1:0] exit_slot,
    input  logic              pay,
    output logic              entry_ack,
    output logic [SLOT_W-1:0] entry_slot,
    output logic              exit_err,
    output logic [FEE_W-1:0]  fee,
    output logic              fee_valid,
    output logic              bar_in,
    output logic              bar_out,
    output logic [SLOT_W:0]   free_cnt,
    output logic              full
);

    localparam int CNT_W = SLOT_W + 1;
    localparam int BAR_W = cnt_w(BAR_CYCLES);

    state_t            state_q, state_d;
    logic              entry_pend_q, entry_pend_d;
    logic              exit_pend_q, exit_pend_d;
    logic [SLOT_W-1:0] exit_id_q, exit_id_d;
    logic              last_q, last_d;
    logic [N_SLOTS-1:0] occ_q, occ_d;
    logic [T_W-1:0]    ts_q [N_SLOTS];
    logic [T_W-1:0]    ts_d [N_SLOTS];
    logic [BAR_W-1:0]  timer_q, timer_d;

    logic              entry_ack_q, entry_ack_d;
    logic [SLOT_W-1:0] entry_slot_q, entry_slot_d;
    logic              exit_err_q, exit_err_d;
    logic [FEE_W-1:0]  fee_q, fee_d;
    logic              fee_valid_q, fee_valid_d;
    logic              bar_in_q, bar_in_d;
    logic              bar_out_q, bar_out_d;
    logic [CNT_W-1:0]  free_cnt_q, free_cnt_d;
    logic              full_q, full_d;

    logic [T_W-1:0]    sec_cnt_s;
    logic              tick_unused_s;
    logic [SLOT_W-1:0] free_idx_s;
    logic              exit_hit_s;
    logic [T_W-1:0]    ts_sel_s;
    logic [T_W-1:0]    elapsed_s;
    logic [FEE_W-1:0]  fee_calc_s;
    logic              exit_elig_s, entry_elig_s;
    logic              entry_clr_s, exit_clr_s;

    park_timebase #(
        .TICK_DIV (TICK_DIV),
        .T_W      (T_W)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .sec_cnt  (sec_cnt_s),
        .tick     (tick_unused_s)
    );

    assign entry_ack  = entry_ack_q;
    assign entry_slot = entry_slot_q;
    assign exit_err   = exit_err_q;
    assign fee        = fee_q;
    assign fee_valid  = fee_valid_q;
    assign bar_in     = bar_in_q;
    assign bar_out    = bar_out_q;
    assign free_cnt   = free_cnt_q;
    assign full       = full_q;

    assign exit_elig_s  = exit_pend_q;
    assign entry_elig_s = entry_pend_q & ~full_q;
    assign elapsed_s    = sec_cnt_s - ts_sel_s;

    // Lowest-index free slot; scanning downward leaves the smallest index.
    always_comb begin
        free_idx_s = {SLOT_W{1'b0}};
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_idx_s = SLOT_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Look up the exiting slot; ids beyond the pool never match and read as free.
    always_comb begin
        exit_hit_s = 1'b0;
        ts_sel_s   = {T_W{1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            if (exit_id_q == SLOT_W'(i)) begin
                exit_hit_s = occ_q[i];
                ts_sel_s   = ts_q[i];
            end else begin
                exit_hit_s = exit_hit_s;
            end
        end
    end

    // Fee band compare chain; an exact hour boundary falls into the next band.
    always_comb begin
        fee_calc_s = FEE_W'(FEE_MAX);
        for (int k = FEE_MAX - 1; k >= 1; k--) begin
            if (longint'(elapsed_s) < longint'(k) * longint'(HOUR_SECS)) begin
                fee_calc_s = FEE_W'(k);
            end else begin
                fee_calc_s = fee_calc_s;
            end
        end
    end

    // Sequencer next-state, slot bookkeeping, request capture and output decode.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        occ_d        = occ_q;
        ts_d         = ts_q;
        timer_d      = timer_q;
        free_cnt_d   = free_cnt_q;
        fee_d        = fee_q;
        entry_slot_d = entry_slot_q;
        entry_ack_d  = 1'b0;
        exit_err_d   = 1'b0;
        entry_clr_s  = 1'b0;
        exit_clr_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exit_elig_s && (!entry_elig_s || last_q == LS_ENTRY)) begin
                    state_d = S_EXIT_CHECK;
                    last_d  = LS_EXIT;
                end else if (entry_elig_s) begin
                    state_d = S_ENTRY_GRANT;
                    last_d  = LS_ENTRY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ENTRY_GRANT: begin
                if (!full_q) begin
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (free_idx_s == SLOT_W'(i)) begin
                            occ_d[i] = 1'b1;
                            ts_d[i]  = sec_cnt_s;
                        end else begin
                            occ_d[i] = occ_q[i];
                        end
                    end
                    entry_ack_d  = 1'b1;
                    entry_slot_d = free_idx_s;
                    entry_clr_s  = 1'b1;
                    free_cnt_d   = free_cnt_q - CNT_W'(1);
                    timer_d      = BAR_W'(BAR_CYCLES - 1);
                    state_d      = S_BAR_IN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BAR_IN: begin
                if (timer_q == {BAR_W{1'b0}}) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - BAR_W'(1);
                end
            end
            S_EXIT_CHECK: begin
                if (!exit_hit_s) begin
                    exit_err_d = 1'b1;
                    exit_clr_s = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    fee_d   = fee_calc_s;
                    state_d = S_WAIT_PAY;
                end
            end
            S_WAIT_PAY: begin
                if (pay) begin
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (exit_id_q == SLOT_W'(i)) begin
                            occ_d[i] = 1'b0;
                        end else begin
                            occ_d[i] = occ_q[i];
                        end
                    end
                    exit_clr_s = 1'b1;
                    free_cnt_d = free_cnt_q + CNT_W'(1);
                    fee_d      = {FEE_W{1'b0}};
                    timer_d    = BAR_W'(BAR_CYCLES - 1);
                    state_d    = S_BAR_OUT;
                end else begin
                    state_d = S_WAIT_PAY;
                end
            end
            S_BAR_OUT: begin
                if (timer_q == {BAR_W{1'b0}}) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - BAR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new entry request merges with a pending one; a set wins over a clear.
        entry_pend_d = (entry_pend_q & ~entry_clr_s) | entry_req;

        // Exit requests latch only when no other exit is outstanding.
        if (exit_req && (!exit_pend_q || exit_clr_s)) begin
            exit_pend_d = 1'b1;
            exit_id_d   = exit_slot;
        end else begin
            exit_pend_d = exit_pend_q & ~exit_clr_s;
            exit_id_d   = exit_id_q;
        end

        bar_in_d    = (state_d == S_BAR_IN);
        bar_out_d   = (state_d == S_BAR_OUT);
        fee_valid_d = (state_d == S_WAIT_PAY);
        full_d      = (free_cnt_d == {CNT_W{1'b0}});
    end

    // State, bookkeeping and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            entry_pend_q <= 1'b0;
            exit_pend_q  <= 1'b0;
            exit_id_q    <= {SLOT_W{1'b0}};
            last_q       <= LS_ENTRY;
            occ_q        <= {N_SLOTS{1'b0}};
            for (int i = 0; i < N_SLOTS; i++) begin
                ts_q[i] <= {T_W{1'b0}};
            end
            timer_q      <= {BAR_W{1'b0}};
            entry_ack_q  <= 1'b0;
            entry_slot_q <= {SLOT_W{1'b0}};
            exit_err_q   <= 1'b0;
            fee_q        <= {FEE_W{1'b0}};
            fee_valid_q  <= 1'b0;
            bar_in_q     <= 1'b0;
            bar_out_q    <= 1'b0;
            free_cnt_q   <= CNT_W'(N_SLOTS);
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_pend_q <= entry_pend_d;
            exit_pend_q  <= exit_pend_d;
            exit_id_q    <= exit_id_d;
            last_q       <= last_d;
            occ_q        <= occ_d;
            ts_q         <= ts_d;
            timer_q      <= timer_d;
            entry_ack_q  <= entry_ack_d;
            entry_slot_q <= entry_slot_d;
            exit_err_q   <= exit_err_d;
            fee_q        <= fee_d;
            fee_valid_q  <= fee_valid_d;
            bar_in_q     <= bar_in_d;
            bar_out_q    <= bar_out_d;
            free_cnt_q   <= free_cnt_d;
            full_q       <= full_d;
        end
    end

endmodule

// File: tb/tb_park_gate_scheduler.sv
// Directed bench for park_gate_scheduler (TICK_DIV=2, BAR_CYCLES=4, HOUR_SECS=10).
module tb_park_gate_scheduler;

    localparam int SLOT_W = 3;
    localparam int FEE_W  = 4;

    logic              clk;
    logic              rst;
    logic              entry_req;
    logic              exit_req;
    logic [SLOT_W-1:0] exit_slot;
    logic              pay;
    logic              entry_ack;
    logic [SLOT_W-1:0] entry_slot;
    logic              exit_err;
    logic [FEE_W-1:0]  fee;
    logic              fee_valid;
    logic              bar_in;
    logic              bar_out;
    logic [SLOT_W:0]   free_cnt;
    logic              full;

    int nvec;
    int nerr;
    int ncyc;
    int ack_cnt;
    int last_slot;
    int ack_ncyc;
    int err_cnt;
    int err_ncyc;
    int bar_in_cnt;
    int bar_out_cnt;
    int bar_out_ncyc;
    int overlap_cnt;
    int exp_free;
    int ts_mdl [5];

    park_gate_scheduler #(
        .N_SLOTS    (5),
        .SLOT_W     (SLOT_W),
        .TICK_DIV   (2),
        .T_W        (16),
        .HOUR_SECS  (10),
        .FEE_MAX    (5),
        .FEE_W      (FEE_W),
        .BAR_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .entry_req  (entry_req),
        .exit_req   (exit_req),
        .exit_slot  (exit_slot),
        .pay        (pay),
        .entry_ack  (entry_ack),
        .entry_slot (entry_slot),
        .exit_err   (exit_err),
        .fee        (fee),
        .fee_valid  (fee_valid),
        .bar_in     (bar_in),
        .bar_out    (bar_out),
        .free_cnt   (free_cnt),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle count since reset; sec_cnt is expected to equal ncyc/2.
    always @(posedge clk) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    // Output event monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (entry_ack) begin
            ack_cnt   <= ack_cnt + 1;
            last_slot <= int'(entry_slot);
            ack_ncyc  <= ncyc;
        end
        if (exit_err) begin
            err_cnt  <= err_cnt + 1;
            err_ncyc <= ncyc;
        end
        if (bar_in) bar_in_cnt <= bar_in_cnt + 1;
        if (bar_out) begin
            bar_out_cnt  <= bar_out_cnt + 1;
            bar_out_ncyc <= ncyc;
        end
        if (bar_in && bar_out) overlap_cnt <= overlap_cnt + 1;
    end

    function automatic int fee_model(input int e);
        if (e >= 40) return 5;
        return e / 10 + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int t);
        int k;
        k = 0;
        while (ncyc < t && k < 2000) begin
            step(1);
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_free = 5;
    endtask

    // Pulse entry_req and wait for the grant; records the stamped second.
    task automatic do_entry(input int exp_slot, input string tag);
        int a0;
        int k;
        a0 = ack_cnt;
        entry_req = 1'b1;
        step(1);
        entry_req = 1'b0;
        k = 0;
        while (ack_cnt == a0 && k < 100) begin
            step(1);
            k++;
        end
        chk({tag, "_ack_seen"}, 32'(k < 100), 32'd1);
        chk({tag, "_slot"}, 32'(last_slot), 32'(exp_slot));
        exp_free--;
        chk({tag, "_free"}, 32'(free_cnt), 32'(exp_free));
        chk({tag, "_full"}, 32'(full), 32'(exp_free == 0));
        ts_mdl[exp_slot] = (ack_ncyc - 1) / 2;
    endtask

    // Exit a car, check fee and latency, pay, and check the exit bar.
    task automatic do_exit(input int slot, input int exp_fee, input string tag);
        int m;
        int k;
        int b0;
        m = ncyc;
        exit_slot = SLOT_W'(slot);
        exit_req  = 1'b1;
        step(1);
        exit_req  = 1'b0;
        exit_slot = '0;
        k = 0;
        while (!fee_valid && k < 50) begin
            step(1);
            k++;
        end
        chk({tag, "_fv_seen"}, 32'(k < 50), 32'd1);
        chk({tag, "_fv_lat"}, 32'(ncyc), 32'(m + 3));
        chk({tag, "_fee"}, 32'(fee), 32'(exp_fee));
        step(3);
        chk({tag, "_fee_hold"}, 32'(fee), 32'(exp_fee));
        b0 = bar_out_cnt;
        pay = 1'b1;
        step(1);
        pay = 1'b0;
        exp_free++;
        chk({tag, "_fv_clr"}, 32'(fee_valid), 32'd0);
        chk({tag, "_free"}, 32'(free_cnt), 32'(exp_free));
        chk({tag, "_bar_out_on"}, 32'(bar_out), 32'd1);
        step(8);
        chk({tag, "_bar_out_len"}, 32'(bar_out_cnt - b0), 32'd4);
    endtask

    initial begin
        int n;
        int a0;
        int b0;
        int e0;
        int m;
        int k;
        int e_tab [4];
        int f_tab [4];
        int bad_slot [3];

        e_tab    = '{9, 10, 39, 45};
        f_tab    = '{1, 2, 4, 5};
        bad_slot = '{3, 5, 6};
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_slot = '0;
        pay       = 1'b0;
        exp_free  = 5;

        // Reset state
        step(3);
        chk("rst_entry_ack", 32'(entry_ack), 32'd0);
        chk("rst_entry_slot", 32'(entry_slot), 32'd0);
        chk("rst_exit_err", 32'(exit_err), 32'd0);
        chk("rst_fee", 32'(fee), 32'd0);
        chk("rst_fee_valid", 32'(fee_valid), 32'd0);
        chk("rst_bars", 32'({bar_in, bar_out}), 32'd0);
        chk("rst_free_cnt", 32'(free_cnt), 32'd5);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b0;

        // 1: first entry, exact latency and bar_in width
        n  = ncyc;
        b0 = bar_in_cnt;
        entry_req = 1'b1;
        step(1);
        entry_req = 1'b0;
        chk("t1_ack_c1", 32'(entry_ack), 32'd0);
        step(1);
        chk("t1_ack_c2", 32'(entry_ack), 32'd0);
        step(1);
        chk("t1_ack_c3", 32'(entry_ack), 32'd1);
        chk("t1_ack_cyc", 32'(ncyc), 32'(n + 3));
        chk("t1_slot", 32'(entry_slot), 32'd0);
        chk("t1_bar_in", 32'(bar_in), 32'd1);
        chk("t1_free", 32'(free_cnt), 32'd4);
        ts_mdl[0] = (ncyc - 1) / 2;
        exp_free = 4;
        step(1);
        chk("t1_ack_pulse", 32'(entry_ack), 32'd0);
        step(6);
        chk("t1_bar_in_len", 32'(bar_in_cnt - b0), 32'd4);
        chk("t1_bar_in_off", 32'(bar_in), 32'd0);

        // 2: fill the pool, sixth car waits, then takes the freed slot 2
        for (int s = 1; s < 5; s++) begin
            do_entry(s, "t2_fill");
            step(6);
        end
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_free_zero", 32'(free_cnt), 32'd0);
        a0 = ack_cnt;
        entry_req = 1'b1;
        step(1);
        entry_req = 1'b0;
        step(20);
        chk("t2_no_ack_full", 32'(ack_cnt), 32'(a0));
        do_exit(2, fee_model((ncyc + 2) / 2 - ts_mdl[2]), "t2_exit");
        k = 0;
        while (ack_cnt == a0 && k < 50) begin
            step(1);
            k++;
        end
        chk("t2_sixth_ack", 32'(k < 50), 32'd1);
        chk("t2_sixth_slot", 32'(last_slot), 32'd2);
        exp_free--;
        step(1);
        chk("t2_sixth_full", 32'(full), 32'd1);
        chk("t2_sixth_free", 32'(free_cnt), 32'(exp_free));
        step(6);

        // 4: simultaneous entry/exit after an entry was served: exit goes first
        do_reset();
        do_entry(0, "t4_pre");
        step(6);
        a0 = ack_cnt;
        b0 = bar_out_cnt;
        m  = ncyc;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_slot = 3'd0;
        step(1);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        k = 0;
        while (!fee_valid && k < 50) begin
            step(1);
            k++;
        end
        chk("t4_exit_first", 32'(k < 50), 32'd1);
        chk("t4_fv_lat", 32'(ncyc), 32'(m + 3));
        chk("t4_fee", 32'(fee), 32'(fee_model((m + 2) / 2 - ts_mdl[0])));
        chk("t4_no_ack_yet", 32'(ack_cnt), 32'(a0));
        pay = 1'b1;
        step(1);
        pay = 1'b0;
        k = 0;
        while (ack_cnt == a0 && k < 50) begin
            step(1);
            k++;
        end
        chk("t4_ack_seen", 32'(k < 50), 32'd1);
        chk("t4_ack_slot", 32'(last_slot), 32'd0);
        chk("t4_bar_out_len", 32'(bar_out_cnt - b0), 32'd4);
        chk("t4_ack_after_bar", 32'(ack_ncyc), 32'(bar_out_ncyc + 3));
        chk("t4_free", 32'(free_cnt), 32'd4);
        exp_free = 4;
        ts_mdl[0] = (ack_ncyc - 1) / 2;
        step(6);

        // 3: fee bands on slot 1
        for (int i = 0; i < 4; i++) begin
            do_entry(1, "t3_entry");
            step(6);
            wait_cyc(2 * (ts_mdl[1] + e_tab[i]) - 2);
            do_exit(1, f_tab[i], "t3_exit");
        end

        // 5: rejected exits (free slot, out-of-range ids)
        for (int i = 0; i < 3; i++) begin
            m  = ncyc;
            e0 = err_cnt;
            b0 = bar_out_cnt;
            exit_slot = SLOT_W'(bad_slot[i]);
            exit_req  = 1'b1;
            step(1);
            exit_req  = 1'b0;
            exit_slot = '0;
            step(5);
            chk("t5_err_pulse", 32'(err_cnt - e0), 32'd1);
            chk("t5_err_cyc", 32'(err_ncyc), 32'(m + 3));
            chk("t5_free", 32'(free_cnt), 32'(exp_free));
            chk("t5_no_bar", 32'(bar_out_cnt), 32'(b0));
            chk("t5_no_fee", 32'(fee_valid), 32'd0);
        end

        // 6: reset while waiting for payment, then while the entry bar is open
        exit_slot = 3'd0;
        exit_req  = 1'b1;
        step(1);
        exit_req  = 1'b0;
        k = 0;
        while (!fee_valid && k < 50) begin
            step(1);
            k++;
        end
        chk("t6_in_wait_pay", 32'(k < 50), 32'd1);
        do_reset();
        chk("t6_rst_fv", 32'(fee_valid), 32'd0);
        chk("t6_rst_fee", 32'(fee), 32'd0);
        chk("t6_rst_bars", 32'({bar_in, bar_out}), 32'd0);
        chk("t6_rst_free", 32'(free_cnt), 32'd5);
        do_entry(0, "t6_entry_a");
        chk("t6_bar_in_open", 32'(bar_in), 32'd1);
        do_reset();
        chk("t6_rst_bar_in", 32'(bar_in), 32'd0);
        chk("t6_rst_ack", 32'(entry_ack), 32'd0);
        chk("t6_rst_free2", 32'(free_cnt), 32'd5);
        chk("t6_rst_full", 32'(full), 32'd0);
        do_entry(0, "t6_entry_b");
        step(6);
        wait_cyc(2 * (ts_mdl[0] + 10) - 2);
        do_exit(0, 2, "t6_exit");

        chk("bar_exclusive", 32'(overlap_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
